// File: rtl/step_recover.sv
// Recovers the per-sample step from a stream of accumulated values and tracks step lock.
// Optional carry-out flag on port `wrap` when STEP_WRAP_EN is defined.
module step_recover #(
  parameter int W      = 8,
  parameter int LOCK_N = 3
) (
  input  logic         ck,
  input  logic         clr,
  input  logic [W-1:0] acc_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] step_out,
  output logic         step_valid,
  input  logic         step_ready,
  output logic         locked,
  output logic         mismatch
`ifdef STEP_WRAP_EN
  ,
  output logic         wrap
`endif
);

  typedef enum logic [1:0] {EMPTY, TRACK, LOCKED} state_t;

  localparam logic [3:0] LOCK_R = 4'(LOCK_N);

  state_t       state_q, state_d;
  logic [W-1:0] prev_q, last_d_q, d;
  logic [3:0]   run_q, run_d, run_inc;
  logic         lock_d, mism_d, same, accept, consume;

  assign in_ready = !step_valid || step_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = step_valid && step_ready;
  assign d        = acc_in - prev_q;
  assign same     = (d == last_d_q);
  // Run saturates at LOCK_N so a long steady stream never overflows the counter.
  assign run_inc  = (run_q >= LOCK_R) ? LOCK_R : run_q + 4'd1;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    lock_d  = locked;
    mism_d  = 1'b0;
    if (accept) begin
      case (state_q)
        EMPTY: begin
          state_d = TRACK;
          run_d   = 4'd0;
        end
        TRACK: begin
          run_d = (run_q == 4'd0 || !same) ? 4'd1 : run_inc;
          if (run_d == LOCK_R) begin
            state_d = LOCKED;
            lock_d  = 1'b1;
          end
        end
        LOCKED: begin
          if (!same) begin
            mism_d  = 1'b1;
            lock_d  = 1'b0;
            state_d = TRACK;
            run_d   = 4'd1;
          end else begin
            run_d = run_inc;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge ck) begin
    if (!clr) begin
      state_q    <= EMPTY;
      prev_q     <= '0;
      last_d_q   <= '0;
      run_q      <= '0;
      step_out   <= '0;
      step_valid <= 1'b0;
      locked     <= 1'b0;
      mismatch   <= 1'b0;
`ifdef STEP_WRAP_EN
      wrap       <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      locked   <= lock_d;
      mismatch <= mism_d;
      if (accept) prev_q <= acc_in;
      // The first sample after EMPTY only primes prev; a new result overrides a same-cycle consume.
      if (accept && state_q != EMPTY) begin
        step_out   <= d;
        step_valid <= 1'b1;
        last_d_q   <= d;
`ifdef STEP_WRAP_EN
        wrap       <= (acc_in < prev_q);
`endif
      end else if (consume) begin
        step_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_step_recover.sv
// Bench for step_recover: directed scenarios plus a randomized run against a delta-history model.
module tb_step_recover;
  localparam int LOCK_N = 3;

  logic       ck = 1'b0;
  logic       clr, in_valid, step_ready;
  logic [7:0] acc_in;
  logic       in_ready, step_valid, locked, mismatch;
  logic [7:0] step_out;
`ifdef STEP_WRAP_EN
  logic       wrap;
`endif

  int passed = 0;
  int total  = 0;

  step_recover #(.W(8), .LOCK_N(LOCK_N)) dut (
    .ck(ck), .clr(clr), .acc_in(acc_in), .in_valid(in_valid), .in_ready(in_ready),
    .step_out(step_out), .step_valid(step_valid), .step_ready(step_ready),
    .locked(locked), .mismatch(mismatch)
`ifdef STEP_WRAP_EN
    , .wrap(wrap)
`endif
  );

  always #5 ck = ~ck;

  // Model: history of recovered deltas since reset; lock = trailing run of equal deltas >= LOCK_N.
  logic       m_valid, m_locked, m_mism, m_wrap, have_prev;
  logic [7:0] m_step, m_prev;
  logic [7:0] dq[$];
  logic       obs_rdy, exp_rdy;

  function automatic int streak();
    int n = 0;
    if (dq.size() == 0) return 0;
    for (int i = dq.size() - 1; i >= 0; i--) begin
      if (dq[i] == dq[dq.size()-1]) n++;
      else break;
    end
    return n;
  endfunction

  task automatic cyc(input logic rn, input logic v, input logic [7:0] dat, input logic r);
    logic [7:0] nd;
    logic       was;
    clr = rn; in_valid = v; acc_in = dat; step_ready = r;
    #1;
    obs_rdy = in_ready;
    exp_rdy = !m_valid || r;
    @(posedge ck);
    m_mism = 1'b0;
    if (!rn) begin
      m_valid = 0; m_step = 0; m_locked = 0; m_wrap = 0; have_prev = 0; m_prev = 0;
      dq.delete();
    end else if (v && exp_rdy) begin
      if (have_prev) begin
        nd  = dat - m_prev;
        was = (streak() >= LOCK_N);
        if (was && nd != dq[dq.size()-1]) m_mism = 1'b1;
        dq.push_back(nd);
        m_locked = (streak() >= LOCK_N);
        m_step   = nd;
        m_wrap   = (dat < m_prev);
        m_valid  = 1'b1;
      end
      have_prev = 1'b1;
      m_prev    = dat;
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(0, 1, 8'h33, 1);
    cyc(0, 0, 8'h00, 0);
    total++; if (step_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", step_valid); else passed++;
    total++; if (step_out !== 8'h00) $display("FAIL reset_step got %h want 00", step_out); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL reset_locked got %b want 0", locked); else passed++;
    total++; if (mismatch !== 1'b0) $display("FAIL reset_mismatch got %b want 0", mismatch); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
`ifdef STEP_WRAP_EN
    total++; if (wrap !== 1'b0) $display("FAIL reset_wrap got %b want 0", wrap); else passed++;
`endif
  endtask

  task automatic test_lock();
    logic [7:0] s [5];
    s = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h14};
    cyc(0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, s[i], 1);
      total++; if (step_valid !== (i > 0)) $display("FAIL lock_valid[%0d] got %b want %b", i, step_valid, i > 0); else passed++;
      if (i > 0) begin
        total++; if (step_out !== 8'h05) $display("FAIL lock_step[%0d] got %h want 05", i, step_out); else passed++;
      end
      total++; if (locked !== (i >= 3)) $display("FAIL lock_locked[%0d] got %b want %b", i, locked, i >= 3); else passed++;
      total++; if (mismatch !== 1'b0) $display("FAIL lock_mismatch[%0d] got %b want 0", i, mismatch); else passed++;
    end
  endtask

  task automatic test_mismatch();
    cyc(1, 1, 8'h1A, 1);
    total++; if (step_out !== 8'h06) $display("FAIL mm_step got %h want 06", step_out); else passed++;
    total++; if (mismatch !== 1'b1) $display("FAIL mm_pulse got %b want 1", mismatch); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL mm_unlock got %b want 0", locked); else passed++;
    cyc(1, 1, 8'h20, 1);
    total++; if (mismatch !== 1'b0) $display("FAIL mm_pulse_end got %b want 0", mismatch); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL mm_relock_early got %b want 0", locked); else passed++;
    cyc(1, 1, 8'h26, 1);
    total++; if (locked !== 1'b1) $display("FAIL mm_relock got %b want 1", locked); else passed++;
    total++; if (step_out !== 8'h06) $display("FAIL mm_step3 got %h want 06", step_out); else passed++;
  endtask

  task automatic test_wrap();
    cyc(1, 1, 8'hFE, 1);
    cyc(1, 1, 8'h03, 1);
    total++; if (step_out !== 8'h05) $display("FAIL wrap_step got %h want 05", step_out); else passed++;
`ifdef STEP_WRAP_EN
    total++; if (wrap !== 1'b1) $display("FAIL wrap_flag got %b want 1", wrap); else passed++;
`endif
    cyc(1, 1, 8'h08, 1);
    total++; if (step_out !== 8'h05) $display("FAIL wrap_step2 got %h want 05", step_out); else passed++;
`ifdef STEP_WRAP_EN
    total++; if (wrap !== 1'b0) $display("FAIL wrap_flag2 got %b want 0", wrap); else passed++;
`endif
  endtask

  task automatic test_backpressure();
    cyc(0, 0, 8'h00, 1);
    cyc(1, 1, 8'h10, 1);
    cyc(1, 1, 8'h13, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 8'h99, 0);
      total++; if (obs_rdy !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b want 0", i, obs_rdy); else passed++;
      total++; if (step_out !== 8'h03 || step_valid !== 1'b1) $display("FAIL bp_hold[%0d] got %h/%b want 03/1", i, step_out, step_valid); else passed++;
      total++; if (locked !== 1'b0) $display("FAIL bp_locked[%0d] got %b want 0", i, locked); else passed++;
    end
    cyc(1, 1, 8'h20, 1);
    total++; if (obs_rdy !== 1'b1) $display("FAIL bp_release_ready got %b want 1", obs_rdy); else passed++;
    total++; if (step_out !== 8'h0D || step_valid !== 1'b1) $display("FAIL bp_release got %h/%b want 0D/1", step_out, step_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    cyc(0, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'(2 * i), 1);
    total++; if (locked !== 1'b1) $display("FAIL rm_prelock got %b want 1", locked); else passed++;
    cyc(0, 1, 8'h77, 1);
    total++; if (step_valid !== 1'b0 || step_out !== 8'h00 || locked !== 1'b0 || mismatch !== 1'b0)
      $display("FAIL rm_clear got v%b s%h l%b m%b want all 0", step_valid, step_out, locked, mismatch); else passed++;
    cyc(1, 1, 8'h40, 1);
    total++; if (step_valid !== 1'b0) $display("FAIL rm_prime got %b want 0", step_valid); else passed++;
    cyc(1, 1, 8'h44, 1);
    total++; if (step_out !== 8'h04 || step_valid !== 1'b1) $display("FAIL rm_step got %h/%b want 04/1", step_out, step_valid); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL rm_locked got %b want 0", locked); else passed++;
  endtask

  task automatic test_zero_step();
    cyc(0, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 8'h07, 1);
      if (i > 0) begin
        total++; if (step_out !== 8'h00 || step_valid !== 1'b1) $display("FAIL zero_step[%0d] got %h/%b want 00/1", i, step_out, step_valid); else passed++;
      end
      total++; if (locked !== (i >= 3)) $display("FAIL zero_locked[%0d] got %b want %b", i, locked, i >= 3); else passed++;
    end
  endtask

  task automatic test_random();
    logic [7:0] cur_step, dat;
    logic       rn, v, r;
    cur_step = 8'h03;
    cyc(0, 0, 8'h00, 1);
    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 199) != 0);
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) cur_step = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 2));
      dat = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255)) : m_prev + cur_step;
      cyc(rn, v, dat, r);
      total++; if (obs_rdy !== exp_rdy) $display("FAIL rnd_in_ready[%0d] got %b want %b", i, obs_rdy, exp_rdy); else passed++;
      total++; if (step_valid !== m_valid) $display("FAIL rnd_valid[%0d] got %b want %b", i, step_valid, m_valid); else passed++;
      total++; if (locked !== m_locked) $display("FAIL rnd_locked[%0d] got %b want %b", i, locked, m_locked); else passed++;
      total++; if (mismatch !== m_mism) $display("FAIL rnd_mismatch[%0d] got %b want %b", i, mismatch, m_mism); else passed++;
      total++; if (step_out !== m_step) $display("FAIL rnd_step[%0d] got %h want %h", i, step_out, m_step); else passed++;
`ifdef STEP_WRAP_EN
      total++; if (wrap !== m_wrap) $display("FAIL rnd_wrap[%0d] got %b want %b", i, wrap, m_wrap); else passed++;
`endif
    end
  endtask

  initial begin
    clr = 1'b0; in_valid = 1'b0; acc_in = 8'h00; step_ready = 1'b1;
    m_valid = 0; m_locked = 0; m_mism = 0; m_wrap = 0; have_prev = 0;
    m_step = 0; m_prev = 0; obs_rdy = 0; exp_rdy = 0;
    test_reset();
    test_lock();
    test_mismatch();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_zero_step();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/step_recover.md
Name: step_recover

Overview:
- Inverse of the counter/accumulator datapath: consumes a stream of accumulated register values and recovers the per-sample step (difference) the accumulator added.
- Tracks whether the step is constant. Asserts `locked` once the step has held steady, and pulses `mismatch` when a locked step changes.
- Sits downstream of an accumulator's `reg_out`, feeding display/LED or checker logic with the recovered step.

Parameters:
- W, 8, data width of accumulated samples and recovered step.
- LOCK_N, 3, number of consecutive equal deltas required to assert `locked` (legal range 1..15).

Ports:
- ck  input  1  rising-edge clock.
- clr  input  1  reset, synchronous, active-low: state clears on a rising `ck` edge while `clr`=0.
- acc_in  input  W  accumulated sample.
- in_valid  input  1  `acc_in` is valid.
- in_ready  output  1  block can accept a sample this cycle.
- step_out  output  W  recovered step, modulo 2^W.
- step_valid  output  1  `step_out` holds an unconsumed result.
- step_ready  input  1  downstream accepts `step_out`.
- locked  output  1  step constant for at least LOCK_N consecutive deltas.
- mismatch  output  1  one-cycle pulse when the step changes while locked.

Behaviour:
- Reset (`clr`=0 at a `ck` edge):
  - state=EMPTY.
  - prev=0, last_d=0, run=0.
  - step_out=0, step_valid=0, locked=0, mismatch=0.
  - Reset overrides any simultaneous accept or output handshake.
- Handshake:
  - `in_ready` = !step_valid || step_ready (single-entry output buffer).
  - Accept = in_valid && in_ready.
  - Output consumed = step_valid && step_ready.
- States: EMPTY, TRACK, LOCKED.
- EMPTY, on accept:
  - prev <= acc_in, state <= TRACK, run <= 0.
  - No output produced (first sample only primes prev).
- TRACK or LOCKED, on accept:
  - d = (acc_in - prev) mod 2^W, unsigned wrap; no saturation.
  - prev <= acc_in, step_out <= d, step_valid <= 1 on the next edge (latency 1 cycle from accept).
  - If run==0 or d!=last_d: run <= 1. Otherwise run <= min(run+1, LOCK_N).
  - last_d <= d.
- Lock rules:
  - TRACK -> LOCKED when the updated run equals LOCK_N; `locked` <= 1 on the same edge.
  - LOCK_N=1: the first delta locks immediately.
- In LOCKED with d!=last_d:
  - mismatch <= 1 for exactly one cycle, locked <= 0, state <= TRACK, run <= 1.
  - step_out still reports the new d.
- `mismatch` is 0 in every cycle not described above.
- Zero step (d=0) is a legal step value and can lock.
- Simultaneous output consume and accept in the same cycle: the new result replaces the old one, and step_valid stays 1.
- Output consume with no accept: step_valid <= 0; step_out holds its last value.
- No accept: prev, run, state and locked hold.
- Backpressure: while step_valid=1 and step_ready=0, step_out, prev and run are frozen.

Optional Feature:
- Macro STEP_WRAP_EN.
- Defined:
  - Adds output port `wrap` (1 bit). Reset value 0.
  - `wrap` is registered alongside step_out: 1 when the delta crossed the modulus (acc_in < prev, unsigned), else 0. This is equivalent to the accumulator's carry-out.
  - `wrap` is valid whenever step_valid=1 and holds under backpressure.
- Undefined: port `wrap` and its logic are absent; all other behaviour is identical.

Test Plan:
- Lock: W=8, LOCK_N=3, step_ready=1; feed 00,05,0A,0F,14 one per cycle.
  - Required: no output for 00; step_out=05 four times.
  - locked=1 on the edge after the third delta (sample 0F is accepted); stays 1 for 14; mismatch=0 throughout.
- Mismatch: continuing from locked at step 05 (last sample 14), feed 1A.
  - Required: step_out=06, mismatch=1 for one cycle, locked=0, state TRACK.
  - Then feed 20, 26: locked re-asserts after the third equal delta of 06.
- Wrap: feed FE then 03.
  - Required: step_out=05.
  - With STEP_WRAP_EN: wrap=1. Next sample 08: step_out=05, wrap=0.
- Backpressure: hold step_ready=0 after the first step_valid=1.
  - Required: in_ready=0; step_out, prev, locked unchanged for 5 cycles while in_valid=1.
  - Raise step_ready: the held sample is consumed and the next sample is accepted in the same cycle.
- Reset mid-stream: while locked, drive clr=0 for one cycle with in_valid=1.
  - Required: all outputs 0 on the next edge and the sample is not accepted.
  - Next accepted sample 40 primes only (no output); following sample 44 gives step_out=04, locked=0.
- Zero step: feed 07,07,07,07 with LOCK_N=3.
  - Required: step_out=00 three times; locked=1 after the third delta.
